// File: rtl/gram_scheduler.sv
// gram_scheduler: presents every vector pair (i,j) of an M-vector matrix to an external inner-product
// engine and collects the results into a flattened M x M Gram matrix. Optional macro: GRAM_SYMMETRIC_EN.
module gram_scheduler #(
   parameter int N     = 100,
   parameter int M     = 4,
   parameter int nBits = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [M*N*nBits-1:0]    matrix,
   input  logic                    ip_endflag,
   input  logic [nBits-1:0]        ip_result,
   output logic [N*nBits-1:0]      ip_vector1,
   output logic [N*nBits-1:0]      ip_vector2,
   output logic                    ip_start,
   output logic                    ip_addSubs,
   output logic [nBits-1:0]        ip_resetValue,
   output logic [nBits-1:0]        ip_maximumPos,
   output logic                    ip_reset,
   output logic                    busy,
   output logic                    done,
   output logic [M*M*nBits-1:0]    gram
);

   localparam int CW = $clog2(M + 1);
   localparam int VW = N * nBits;
   localparam logic [CW-1:0] LAST = CW'(M - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_STORE  = 3'd3;
   localparam logic [2:0] S_NEXT   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]       state_r;
   logic [2:0]       state_s;
   logic [CW-1:0]    i_r;
   logic [CW-1:0]    j_r;
   logic [CW-1:0]    i_s;
   logic [CW-1:0]    j_s;
   logic             first_r;
   logic [nBits-1:0] result_r;
   logic [nBits-1:0] gram_r [M*M];
   logic [M*M-1:0]   hit_s;
   logic             busy_r;
   logic             done_r;
   logic             ip_start_r;
   logic             ip_reset_r;
   int               idx_s;
   int               idx_t_s;

   // Next state and row-major pair advance
   always_comb begin
      state_s = state_r;
      i_s     = i_r;
      j_s     = j_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = S_LAUNCH;
               i_s     = {CW{1'b0}};
               j_s     = {CW{1'b0}};
            end else begin
               state_s = S_IDLE;
            end
         end
         S_LAUNCH: state_s = S_WAIT;
         S_WAIT: begin
            // the first WAIT cycle may still see the previous product's flag
            if (!first_r && ip_endflag) begin
               state_s = S_STORE;
            end else begin
               state_s = S_WAIT;
            end
         end
         S_STORE: state_s = S_NEXT;
         S_NEXT: begin
            if ((i_r == LAST) && (j_r == LAST)) begin
               state_s = S_DONE;
            end else if (j_r == LAST) begin
               state_s = S_LAUNCH;
               i_s     = i_r + ONE;
`ifdef GRAM_SYMMETRIC_EN
               j_s     = i_r + ONE;
`else
               j_s     = {CW{1'b0}};
`endif
            end else begin
               state_s = S_LAUNCH;
               j_s     = j_r + ONE;
            end
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Gram write-enable decode for the current pair (and its mirror)
   always_comb begin
      idx_s   = int'(i_r) * M + int'(j_r);
`ifdef GRAM_SYMMETRIC_EN
      idx_t_s = int'(j_r) * M + int'(i_r);
`else
      idx_t_s = idx_s;
`endif
      hit_s = {(M*M){1'b0}};
      for (int k = 0; k < M*M; k++) begin
         hit_s[k] = (state_r == S_STORE) && ((k == idx_s) || (k == idx_t_s));
      end
   end

   // Operand selection by the registered pair indices
   always_comb begin
      ip_vector1 = {VW{1'b0}};
      ip_vector2 = {VW{1'b0}};
      for (int k = 0; k < M; k++) begin
         ip_vector1 = (i_r == CW'(k)) ? matrix[k*VW +: VW] : ip_vector1;
         ip_vector2 = (j_r == CW'(k)) ? matrix[k*VW +: VW] : ip_vector2;
      end
   end

   // FSM, counters, result latch and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= S_IDLE;
         i_r        <= {CW{1'b0}};
         j_r        <= {CW{1'b0}};
         first_r    <= 1'b0;
         result_r   <= {nBits{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ip_start_r <= 1'b0;
         ip_reset_r <= 1'b1;
      end else begin
         state_r    <= state_s;
         i_r        <= i_s;
         j_r        <= j_s;
         first_r    <= (state_r == S_LAUNCH);
         if ((state_r == S_WAIT) && !first_r && ip_endflag) begin
            result_r <= ip_result;
         end else begin
            result_r <= result_r;
         end
         busy_r     <= (state_s == S_LAUNCH) || (state_s == S_WAIT) ||
                       (state_s == S_STORE)  || (state_s == S_NEXT);
         done_r     <= (state_s == S_DONE);
         ip_start_r <= (state_s == S_LAUNCH);
         ip_reset_r <= (state_s == S_IDLE) || (state_s == S_DONE);
      end
   end

   // Gram storage; survives start and is only cleared by reset
   always_ff @(posedge clk) begin
      for (int k = 0; k < M*M; k++) begin
         if (reset) begin
            gram_r[k] <= {nBits{1'b0}};
         end else if (hit_s[k]) begin
            gram_r[k] <= result_r;
         end else begin
            gram_r[k] <= gram_r[k];
         end
      end
   end

   for (genvar g = 0; g < M*M; g++) begin : g_pack
      assign gram[g*nBits +: nBits] = gram_r[g];
   end

   assign ip_start      = ip_start_r;
   assign ip_reset      = ip_reset_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign ip_addSubs    = 1'b1;
   assign ip_resetValue = {nBits{1'b0}};
   assign ip_maximumPos = nBits'(N - 1);

endmodule

// File: tb/tb_gram_scheduler.sv
// Self-checking bench for gram_scheduler: behavioural engine, pair/gram model and directed runs
// on an M=2,N=3 instance plus a hand-driven M=1,N=1 instance.
`timescale 1ns/1ps
module tb_gram_scheduler;
   localparam int N = 3;
   localparam int M = 2;
   localparam int W = 32;
`ifdef GRAM_SYMMETRIC_EN
   localparam bit SYM = 1'b1;
`else
   localparam bit SYM = 1'b0;
`endif
   localparam int PAIRS = SYM ? (M * (M + 1)) / 2 : M * M;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, start, ip_endflag;
   logic [M*N*W-1:0]   matrix;
   logic [W-1:0]       ip_result, ip_resetValue, ip_maximumPos;
   logic [N*W-1:0]     ip_vector1, ip_vector2;
   logic               ip_start, ip_addSubs, ip_reset, busy, done;
   logic [M*M*W-1:0]   gram;

   logic               b_start, b_endflag, b_ip_start, b_addsubs, b_ip_reset, b_busy, b_done;
   logic [W-1:0]       b_matrix, b_result, b_v1, b_v2, b_resetvalue, b_maxpos, b_gram;

   gram_scheduler #(.N(N), .M(M), .nBits(W)) u_dut (
      .clk(clk), .reset(reset), .start(start), .matrix(matrix),
      .ip_endflag(ip_endflag), .ip_result(ip_result),
      .ip_vector1(ip_vector1), .ip_vector2(ip_vector2), .ip_start(ip_start),
      .ip_addSubs(ip_addSubs), .ip_resetValue(ip_resetValue), .ip_maximumPos(ip_maximumPos),
      .ip_reset(ip_reset), .busy(busy), .done(done), .gram(gram));

   gram_scheduler #(.N(1), .M(1), .nBits(W)) u_dut1 (
      .clk(clk), .reset(reset), .start(b_start), .matrix(b_matrix),
      .ip_endflag(b_endflag), .ip_result(b_result),
      .ip_vector1(b_v1), .ip_vector2(b_v2), .ip_start(b_ip_start),
      .ip_addSubs(b_addsubs), .ip_resetValue(b_resetvalue), .ip_maximumPos(b_maxpos),
      .ip_reset(b_ip_reset), .busy(b_busy), .done(b_done), .gram(b_gram));

   int compared = 0;
   int mismatched = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   bit chk_en = 1'b0;

   // model state
   int vec [M][N];
   int eg [M*M];
   int pq_i [$];
   int pq_j [$];

   // engine model state
   int tlat = 5;
   bit stale_mode = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N*W-1:0] vec_bits(input int v);
      logic [N*W-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = vec[v][k];
      return r;
   endfunction

   function automatic logic [M*N*W-1:0] pack_matrix();
      logic [M*N*W-1:0] r;
      for (int v = 0; v < M; v++) r[v*N*W +: N*W] = vec_bits(v);
      return r;
   endfunction

   function automatic int dotv(input int a, input int b);
      int s = 0;
      for (int k = 0; k < N; k++) s += vec[a][k] * vec[b][k];
      return s;
   endfunction

   function automatic logic [W-1:0] dot_bits(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
      logic [W-1:0] s = '0;
      for (int k = 0; k < N; k++) s += a[k*W +: W] * b[k*W +: W];
      return s;
   endfunction

   function automatic logic [M*M*W-1:0] exp_gram();
      logic [M*M*W-1:0] r;
      for (int k = 0; k < M*M; k++) r[k*W +: W] = eg[k];
      return r;
   endfunction

   task automatic set_vecs(input int a0, input int a1, input int a2,
                           input int b0, input int b1, input int b2);
      vec[0][0] = a0; vec[0][1] = a1; vec[0][2] = a2;
      vec[1][0] = b0; vec[1][1] = b1; vec[1][2] = b2;
      matrix = pack_matrix();
   endtask

   // Expected pair order and Gram contents straight from the pair-walk rules
   task automatic build_model();
      pq_i.delete();
      pq_j.delete();
      for (int i = 0; i < M; i++) begin
         for (int j = (SYM ? i : 0); j < M; j++) begin
            pq_i.push_back(i);
            pq_j.push_back(j);
            eg[i*M+j] = dotv(i, j);
            if (SYM) eg[j*M+i] = dotv(i, j);
         end
      end
   endtask

   // Behavioural engine: result tlat cycles after ip_start, optional stale flag around launch
   initial begin
      int cnt;
      logic [W-1:0] val;
      cnt = 0; val = '0;
      ip_endflag = 1'b0; ip_result = '0;
      forever begin
         @(posedge clk); #1;
         if (!busy && !ip_start) begin
            cnt = 0; ip_endflag = 1'b0; ip_result = '0;
         end else if (ip_start) begin
            cnt = tlat;
            val = dot_bits(ip_vector1, ip_vector2);
            ip_endflag = stale_mode;
            ip_result = stale_mode ? 32'hDEADBEEF : 32'd0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               ip_endflag = 1'b1; ip_result = val;
            end else if (stale_mode && cnt == tlat - 1) begin
               ip_endflag = 1'b1; ip_result = 32'hDEADBEEF;
            end else begin
               ip_endflag = 1'b0; ip_result = '0;
            end
         end else begin
            ip_endflag = 1'b0; ip_result = '0;
         end
      end
   end

   // Per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("ip_reset_eq_not_busy", ip_reset, !busy);
            if (done) begin
               chk("done_while_busy", busy, 1'b0);
               chk("gram_at_done", gram, exp_gram());
               done_cnt++;
            end
            if (ip_start) begin
               start_cnt++;
               chk("start_expected", (pq_i.size() > 0), 1'b1);
               chk("maximumPos", ip_maximumPos, N - 1);
               chk("resetValue", ip_resetValue, 0);
               chk("addSubs", ip_addSubs, 1'b1);
               if (pq_i.size() > 0) begin
                  chk("vector1", ip_vector1, vec_bits(pq_i[0]));
                  chk("vector2", ip_vector2, vec_bits(pq_j[0]));
                  void'(pq_i.pop_front());
                  void'(pq_j.pop_front());
               end
            end
         end
      end
   end

   task automatic run_gram(input int t, input bit stale, input bit poke, input string tag);
      int cyc, s0, d0;
      tlat = t; stale_mode = stale;
      build_model();
      s0 = start_cnt; d0 = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         start = poke && (cyc == 3);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_cycles"}, cyc + 1, PAIRS * (3 + t) + 1);
      chk({tag, "_starts"}, start_cnt - s0, PAIRS);
      @(posedge clk); #1;
      chk({tag, "_done_width"}, done, 1'b0);
      chk({tag, "_busy_after"}, busy, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_done_count"}, done_cnt - d0, 1);
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_queue_empty"}, pq_i.size(), 0);
   endtask

   initial begin
      int s0, guard;
      reset = 1'b1; start = 1'b0;
      b_start = 1'b0; b_endflag = 1'b0; b_result = '0; b_matrix = '0;
      set_vecs(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_gram", gram, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ip_start", ip_start, 1'b0);
      chk("rst_ip_reset", ip_reset, 1'b1);
      reset = 1'b0;
      @(posedge clk); #1;

      // full computation
      set_vecs(1, 2, 3, 4, 5, 6);
      build_model();
      chk("model_g00", eg[0], 14);
      chk("model_g01", eg[1], 32);
      chk("model_g10", eg[2], 32);
      chk("model_g11", eg[3], 77);
      run_gram(5, 1'b0, 1'b0, "full");
      chk("full_gram_literal", gram, {32'd77, 32'd32, 32'd32, 32'd14});
      chk("full_gram_held", gram, exp_gram());

      // stale end flag around launch
      set_vecs(1, 2, 2, 0, 0, 3);
      run_gram(4, 1'b1, 1'b0, "stale");
      chk("stale_g00_literal", gram[W-1:0], 9);

      // mid-operation reset during WAIT of pair (0,1)
      set_vecs(1, 2, 3, 4, 5, 6);
      build_model();
      tlat = 5; stale_mode = 1'b0;
      s0 = start_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (start_cnt - s0 < 2 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("abort_reached_pair2", start_cnt - s0, 2);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_gram", gram, 0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_ip_reset", ip_reset, 1'b1);
      pq_i.delete(); pq_j.delete();
      repeat (2) @(posedge clk);
      #1;
      run_gram(5, 1'b0, 1'b0, "after_reset");

      // start pulsed while busy
      run_gram(5, 1'b0, 1'b1, "poke");

      // degenerate M=1, N=1
      b_matrix = 32'd7;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      chk("m1_ip_start", b_ip_start, 1'b1);
      chk("m1_vector1", b_v1, 32'd7);
      chk("m1_vector2", b_v2, 32'd7);
      chk("m1_maxpos", b_maxpos, 32'd0);
      chk("m1_resetvalue", b_resetvalue, 32'd0);
      chk("m1_addsubs", b_addsubs, 1'b1);
      @(posedge clk); #1;
      chk("m1_start_width", b_ip_start, 1'b0);
      @(posedge clk); #1;
      b_endflag = 1'b1; b_result = 32'd49;
      @(posedge clk); #1;
      b_endflag = 1'b0; b_result = 32'd0;
      chk("m1_store_busy", b_busy, 1'b1);
      @(posedge clk); #1;
      chk("m1_gram", b_gram, 32'd49);
      chk("m1_next_done", b_done, 1'b0);
      @(posedge clk); #1;
      chk("m1_done", b_done, 1'b1);
      chk("m1_done_busy", b_busy, 1'b0);
      @(posedge clk); #1;
      chk("m1_done_width", b_done, 1'b0);
      chk("m1_idle_ip_reset", b_ip_reset, 1'b1);
      chk("m1_gram_held", b_gram, 32'd49);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
